// File: rtl/serial_pkg.sv
// Shared types and defaults for the byte serializer slice.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SEL_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/bit_index_counter.sv
// Up/down bit-index counter with a reload to the first index and a last-index flag.
module bit_index_counter #(
  parameter int               SEL_W     = 3,
  parameter logic [SEL_W-1:0] FIRST_IDX = '0,
  parameter logic [SEL_W-1:0] LAST_IDX  = '1,
  parameter bit               DOWN      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  output logic [SEL_W-1:0] idx,
  output logic             last
);

  localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

  // Reload wins over stepping; wrap-around is left to the natural SEL_W overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= FIRST_IDX;
    end else if (load) begin
      idx <= FIRST_IDX;
    end else if (enable) begin
      idx <= DOWN ? (idx - ONE) : (idx + ONE);
    end
  end

  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial front end that steps an external 8:1 mux and forwards its output bit.
module byte_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] mux_data,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_bit,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0) || (WIDTH != (1 << SEL_W))) begin : g_bad_width
    $error("byte_serializer: WIDTH must be a power of two >= 2 and equal 2**SEL_W");
  end

  ser_state_t       state;
  ser_state_t       state_next;
  logic [WIDTH-1:0] hold;
  logic             last_idx;
  logic             accept;
  logic             xfer;
  logic             load_idx;
  logic             step_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A last-bit transfer doubles as an acceptance slot, so words can run back to back.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_last  = last_idx;
        in_ready  = last_idx && ser_ready;
        if (last_idx && ser_ready && !in_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign xfer     = ser_valid && ser_ready;
  assign load_idx = accept || (xfer && last_idx);
  assign step_idx = xfer && !last_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (accept) begin
      hold <= in_data;
    end
  end

  bit_index_counter #(
    .SEL_W    (SEL_W),
    .FIRST_IDX(FIRST_IDX),
    .LAST_IDX (LAST_IDX),
    .DOWN     (MSB_FIRST)
  ) u_index (
    .clk   (clk),
    .rst   (rst),
    .load  (load_idx),
    .enable(step_idx),
    .idx   (mux_sel),
    .last  (last_idx)
  );

  assign mux_data = hold;
  assign ser_bit  = mux_bit;

endmodule

// File: tb/tb_byte_serializer.sv
// Drives an LSB-first and an MSB-first serializer in lockstep against a bit-queue model.
module tb_byte_serializer;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             serReady;

  logic             inReady[2];
  logic [WIDTH-1:0] muxData[2];
  logic [SEL_W-1:0] muxSel[2];
  logic             muxBit[2];
  logic             serBit[2];
  logic             serValid[2];
  logic             serLast[2];
  logic             busy[2];

  int checkCount = 0;
  int passCount  = 0;

  bit               q0[$];
  bit               q1[$];
  logic [WIDTH-1:0] word0;
  logic [WIDTH-1:0] word1;

  assign muxBit[0] = muxData[0][muxSel[0]];
  assign muxBit[1] = muxData[1][muxSel[1]];

  byte_serializer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady[0]),
    .mux_data(muxData[0]), .mux_sel(muxSel[0]), .mux_bit(muxBit[0]), .ser_bit(serBit[0]),
    .ser_valid(serValid[0]), .ser_last(serLast[0]), .ser_ready(serReady), .busy(busy[0])
  );

  byte_serializer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady[1]),
    .mux_data(muxData[1]), .mux_sel(muxSel[1]), .mux_bit(muxBit[1]), .ser_bit(serBit[1]),
    .ser_valid(serValid[1]), .ser_last(serLast[1]), .ser_ready(serReady), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // n pending bits, front is the next bit due; the front bit's index follows from n.
  task automatic checkOne(input int d, input int n, input bit front, input logic [WIDTH-1:0] word);
    string p;
    p = (d == 1) ? "msb" : "lsb";
    chk({p, ".in_ready"}, 32'(inReady[d]), 32'((n == 0) || (n == 1 && serReady)));
    chk({p, ".ser_valid"}, 32'(serValid[d]), 32'(n != 0));
    chk({p, ".busy"}, 32'(busy[d]), 32'(n != 0));
    chk({p, ".ser_last"}, 32'(serLast[d]), 32'(n == 1));
    chk({p, ".mux_data"}, 32'(muxData[d]), 32'(word));
    if (n != 0) begin
      chk({p, ".ser_bit"}, 32'(serBit[d]), 32'(front));
      chk({p, ".mux_sel"}, 32'(muxSel[d]), (d == 1) ? 32'(n - 1) : 32'(WIDTH - n));
    end
  endtask

  task automatic checkOutput();
    checkOne(0, q0.size(), (q0.size() != 0) ? q0[0] : 1'b0, word0);
    checkOne(1, q1.size(), (q1.size() != 0) ? q1[0] : 1'b0, word1);
  endtask

  // One clock cycle: drive, check before the edge, advance the model, cross the edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bit acc;
    inValid  = v;
    inData   = d;
    serReady = r;
    #1;
    checkOutput();
    acc = v && ((q0.size() == 0) || (q0.size() == 1 && r));
    if (q0.size() != 0 && r) void'(q0.pop_front());
    if (q1.size() != 0 && r) void'(q1.pop_front());
    if (acc) begin
      word0 = d;
      word1 = d;
      for (int i = 0; i < WIDTH; i++) begin
        q0.push_back(d[i]);
        q1.push_back(d[WIDTH-1-i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetNow();
    #3;
    rst     = 1'b1;
    inValid = 1'b0;
    q0.delete();
    q1.delete();
    word0 = '0;
    word1 = '0;
    #1;
    checkOutput();
    chk("lsb.reset_sel", 32'(muxSel[0]), 32'd0);
    chk("msb.reset_sel", 32'(muxSel[1]), 32'(WIDTH - 1));
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    inData   = '0;
    inValid  = 1'b0;
    serReady = 1'b1;
    word0    = '0;
    word1    = '0;
    @(posedge clk);
    #1;
    resetNow();

    applyStimulus(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'($urandom), 1'b1);

    applyStimulus(1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'($urandom), 1'b1);

    applyStimulus(1'b1, 8'h3C, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'($urandom), 1'b1);

    applyStimulus(1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    applyStimulus(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    resetNow();
    applyStimulus(1'b1, 8'h96, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
